// File: rtl/bus_slave_mem.sv
// bus_slave_mem: memory-backed system-bus slave with programmable wait states.
// Define SLAVE_SPLIT_EN to build in SPLIT/RETRY handling and the sb_split_ar release.
module bus_slave_mem #(
  parameter int ADDR_W       = 12,
  parameter int DEPTH        = 4096,
  parameter int LATENCY      = 2,
  parameter int SPLIT_THRESH = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic [13:0] haddr,
  input  logic        hwrite,
  input  logic [31:0] wdata,
  input  logic [1:0]  sb_masters,
  input  logic        sb_mastlock,
  output logic [31:0] rdata,
  output logic [1:0]  resp,
  output logic        ready,
  output logic [1:0]  sb_split_ar
);

`ifdef SLAVE_SPLIT_EN
  localparam bit SPLIT_BUILD = 1'b1;
`else
  localparam bit SPLIT_BUILD = 1'b0;
`endif
  localparam bit SPLIT_ON = SPLIT_BUILD && (LATENCY > SPLIT_THRESH);
  localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LIMIT    = (DEPTH < 2**ADDR_W) ? DEPTH : 2**ADDR_W;

  localparam logic [1:0] R_OKAY  = 2'b00;
  localparam logic [1:0] R_ERROR = 2'b01;
  localparam logic [1:0] R_RETRY = 2'b10;
  localparam logic [1:0] R_SPLIT = 2'b11;

  typedef enum logic [2:0] {IDLE, WAIT, ERR2, SPL2, SPLIT_BUSY, RTY2} state_t;
  state_t state, state_nx;

  logic [31:0]      mem [DEPTH];
  logic [13:0]      a_addr;
  logic             a_write;
  logic [31:0]      a_wdata;
  logic [1:0]       a_owner;
  logic [3:0]       cnt, cnt_nx;
  logic             sp_busy, sp_busy_nx;
  logic [3:0]       sp_cnt, sp_cnt_nx;
  logic             buf_valid, buf_valid_nx;
  logic [31:0]      buf_data, buf_data_nx;
  logic [31:0]      rdata_nx;
  logic [1:0]       resp_nx, split_ar_nx;
  logic             ready_nx;
  logic             cap, rel_now, mapped, hit, split_ok;
  logic             mem_we;
  logic [IDX_W-1:0] mem_waddr, a_idx, in_idx;
  logic [31:0]      mem_wdat;

  assign a_idx    = a_addr[IDX_W-1:0];
  assign in_idx   = haddr[IDX_W-1:0];
  // Full-width unsigned compare: high address bits never alias onto implemented words.
  assign mapped   = 32'(haddr) < LIMIT;
  assign hit      = SPLIT_ON && buf_valid && (sb_masters == a_owner) &&
                    (haddr == a_addr) && (hwrite == a_write);
  assign split_ok = SPLIT_ON && !sb_mastlock && (sb_masters != 2'b00) && !sp_busy;

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    rdata_nx     = rdata;
    resp_nx      = R_OKAY;
    ready_nx     = ready;
    split_ar_nx  = '0;
    cap          = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = a_idx;
    mem_wdat     = a_wdata;
    sp_busy_nx   = sp_busy;
    sp_cnt_nx    = sp_cnt;
    buf_valid_nx = buf_valid;
    buf_data_nx  = buf_data;
    rel_now      = 1'b0;

    // The split countdown runs beside the front end so RETRY handshakes never stall it.
    if (state == SPL2) begin
      sp_busy_nx = 1'b1;
      sp_cnt_nx  = 4'(LATENCY - 1);
      rel_now    = (LATENCY == 1);
    end else if (sp_busy) begin
      if (sp_cnt == 4'd0) begin
        sp_busy_nx = 1'b0;
      end else begin
        sp_cnt_nx = sp_cnt - 4'd1;
        rel_now   = (sp_cnt == 4'd1);
      end
    end
    if (rel_now) begin
      split_ar_nx  = a_owner;
      buf_valid_nx = 1'b1;
      if (a_write) mem_we = 1'b1;
      else         buf_data_nx = mem[a_idx];
    end

    unique case (state)
      IDLE, SPLIT_BUSY: begin
        state_nx = sp_busy_nx ? SPLIT_BUSY : IDLE;
        if (sel && ready) begin
          if (sp_busy) begin
            state_nx = RTY2;
            ready_nx = 1'b0;
            resp_nx  = R_RETRY;
          end else begin
            cap          = 1'b1;
            buf_valid_nx = 1'b0;
            if (hit) begin
              ready_nx = 1'b1;
              if (!hwrite) rdata_nx = buf_data;
            end else if (!mapped) begin
              state_nx = ERR2;
              ready_nx = 1'b0;
              resp_nx  = R_ERROR;
            end else if (split_ok) begin
              state_nx = SPL2;
              ready_nx = 1'b0;
              resp_nx  = R_SPLIT;
            end else if (LATENCY == 0) begin
              ready_nx = 1'b1;
              if (hwrite) begin
                mem_we    = 1'b1;
                mem_waddr = in_idx;
                mem_wdat  = wdata;
              end else begin
                rdata_nx = mem[in_idx];
              end
            end else begin
              state_nx = WAIT;
              ready_nx = 1'b0;
              cnt_nx   = 4'(LATENCY - 1);
            end
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nx = IDLE;
          ready_nx = 1'b1;
          if (a_write) mem_we = 1'b1;
          else         rdata_nx = mem[a_idx];
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      ERR2: begin
        state_nx = IDLE;
        ready_nx = 1'b1;
        resp_nx  = R_ERROR;
      end
      SPL2: begin
        state_nx = SPLIT_BUSY;
        ready_nx = 1'b1;
        resp_nx  = R_SPLIT;
      end
      RTY2: begin
        state_nx = sp_busy_nx ? SPLIT_BUSY : IDLE;
        ready_nx = 1'b1;
        resp_nx  = R_RETRY;
      end
      default: begin
        state_nx = IDLE;
        ready_nx = 1'b1;
      end
    endcase

    if (rst) mem_we = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      rdata       <= '0;
      resp        <= R_OKAY;
      ready       <= 1'b1;
      sb_split_ar <= '0;
      sp_busy     <= 1'b0;
      sp_cnt      <= '0;
      buf_valid   <= 1'b0;
      buf_data    <= '0;
      a_addr      <= '0;
      a_write     <= 1'b0;
      a_wdata     <= '0;
      a_owner     <= '0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      rdata       <= rdata_nx;
      resp        <= resp_nx;
      ready       <= ready_nx;
      sb_split_ar <= split_ar_nx;
      sp_busy     <= sp_busy_nx;
      sp_cnt      <= sp_cnt_nx;
      buf_valid   <= buf_valid_nx;
      buf_data    <= buf_data_nx;
      if (cap) begin
        a_addr  <= haddr;
        a_write <= hwrite;
        a_wdata <= wdata;
        a_owner <= sb_masters;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdat;
  end

endmodule

// File: tb/tb_bus_slave_mem.sv
// tb_bus_slave_mem: directed and randomized transfers against a transaction-level model
// of bus_slave_mem (wait states, ERROR, and SPLIT/RETRY when SLAVE_SPLIT_EN is defined).
module tb_bus_slave_mem;
  localparam int LAT    = 4;
  localparam int DEPTH  = 1024;
  localparam int THRESH = 1;
`ifdef SLAVE_SPLIT_EN
  localparam bit SPLIT_ON = 1'b1;
`else
  localparam bit SPLIT_ON = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b0, sel = 1'b0, hwrite = 1'b0, sb_mastlock = 1'b0;
  logic [13:0] haddr = '0;
  logic [31:0] wdata = '0;
  logic [1:0]  sb_masters = '0;
  logic [31:0] rdata;
  logic [1:0]  resp, sb_split_ar;
  logic        ready;

  always #5 clk = ~clk;

  bus_slave_mem #(.ADDR_W(12), .DEPTH(DEPTH), .LATENCY(LAT), .SPLIT_THRESH(THRESH)) dut (
    .clk(clk), .rst(rst), .sel(sel), .haddr(haddr), .hwrite(hwrite), .wdata(wdata),
    .sb_masters(sb_masters), .sb_mastlock(sb_mastlock), .rdata(rdata), .resp(resp),
    .ready(ready), .sb_split_ar(sb_split_ar)
  );

  int          tests = 0, fails = 0;
  logic [31:0] ref_mem [DEPTH];
  int          written_q[$];
  bit          written [DEPTH];
  logic [31:0] last_rd = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_write(input logic [13:0] a, input logic [31:0] d);
    ref_mem[32'(a)] = d;
    if (!written[32'(a)]) begin
      written[32'(a)] = 1'b1;
      written_q.push_back(32'(a));
    end
  endtask

  // One complete transfer, with every response cycle predicted from the bus rules.
  task automatic xfer(input logic [13:0] a, input bit wr, input logic [31:0] d,
                      input logic [1:0] m, input bit lk, input bit follow);
    int n;
    logic [31:0] exp_rd;
    chk("pre_ready", 32'(ready), 32'd1);
    sel = 1'b1; haddr = a; hwrite = wr; wdata = d; sb_masters = m; sb_mastlock = lk;
    tick();
    sel = 1'b0; haddr = 14'($urandom); hwrite = 1'($urandom); wdata = $urandom;
    if (32'(a) >= DEPTH) begin
      chk("err_c1_ready", 32'(ready), 32'd0);
      chk("err_c1_resp", 32'(resp), 32'd1);
      tick();
      chk("err_c2_ready", 32'(ready), 32'd1);
      chk("err_c2_resp", 32'(resp), 32'd1);
      chk("err_rdata_hold", rdata, last_rd);
    end else if (SPLIT_ON && LAT > THRESH && !lk && m != 2'b00) begin
      chk("spl_c1_ready", 32'(ready), 32'd0);
      chk("spl_c1_resp", 32'(resp), 32'd3);
      tick();
      chk("spl_c2_ready", 32'(ready), 32'd1);
      chk("spl_c2_resp", 32'(resp), 32'd3);
      n = 0;
      while (sb_split_ar == 2'b00 && n < 20) begin
        tick();
        n++;
      end
      chk("spl_release_delay", 32'(n), 32'(LAT - 1));
      chk("spl_release_owner", 32'(sb_split_ar), 32'(m));
      if (wr) model_write(a, d);
      tick();
      chk("spl_release_width", 32'(sb_split_ar), 32'd0);
      if (follow) begin
        sel = 1'b1; haddr = a; hwrite = wr; wdata = d; sb_masters = m; sb_mastlock = 1'b0;
        tick();
        sel = 1'b0;
        exp_rd = wr ? last_rd : ref_mem[32'(a)];
        chk("spl_hit_ready", 32'(ready), 32'd1);
        chk("spl_hit_resp", 32'(resp), 32'd0);
        chk("spl_hit_rdata", rdata, exp_rd);
        last_rd = exp_rd;
      end
    end else begin
      for (int i = 0; i < LAT; i++) begin
        chk("wait_ready", 32'(ready), 32'd0);
        chk("wait_resp", 32'(resp), 32'd0);
        tick();
      end
      if (wr) model_write(a, d);
      exp_rd = wr ? last_rd : ref_mem[32'(a)];
      chk("ok_ready", 32'(ready), 32'd1);
      chk("ok_resp", 32'(resp), 32'd0);
      chk("ok_rdata", rdata, exp_rd);
      last_rd = exp_rd;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          wr, lk;
    logic [1:0]  m;
    logic [13:0] a;

    #1 rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_resp", 32'(resp), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_split_ar", 32'(sb_split_ar), 32'd0);
    @(negedge clk) rst = 1'b0;
    tick();

    // Basic write/read with wait states, resp returning to OKAY, rdata holding.
    xfer(14'h010, 1'b1, 32'hDEADBEEF, 2'b01, 1'b1, 1'b1);
    xfer(14'h000, 1'b1, 32'hA5A50000, 2'b01, 1'b1, 1'b1);
    xfer(14'h3FF, 1'b1, 32'h0BADF00D, 2'b10, 1'b1, 1'b1);
    xfer(14'h010, 1'b0, 32'h0, 2'b01, 1'b1, 1'b1);
    chk("t1_rdata", rdata, 32'hDEADBEEF);
    tick();
    chk("t1_resp_after", 32'(resp), 32'd0);
    chk("t1_rdata_hold", rdata, 32'hDEADBEEF);

    // Unmapped boundary then a normal read.
    xfer(14'h0400, 1'b0, 32'h0, 2'b01, 1'b0, 1'b1);
    xfer(14'h3FFF, 1'b1, 32'h11111111, 2'b10, 1'b1, 1'b1);
    xfer(14'h000, 1'b0, 32'h0, 2'b01, 1'b1, 1'b1);
    xfer(14'h3FF, 1'b0, 32'h0, 2'b01, 1'b1, 1'b1);

    // Split read by M1 with buffered re-read.
    xfer(14'h020, 1'b1, 32'h12345678, 2'b01, 1'b1, 1'b1);
    xfer(14'h020, 1'b0, 32'h0, 2'b01, 1'b0, 1'b1);
    chk("t3_rdata", rdata, 32'h12345678);

`ifdef SLAVE_SPLIT_EN
    // M2 collides with M1's split countdown and is told to retry.
    sel = 1'b1; haddr = 14'h020; hwrite = 1'b0; sb_masters = 2'b01; sb_mastlock = 1'b0;
    tick();
    sel = 1'b0;
    chk("t4_spl1_resp", 32'(resp), 32'd3);
    tick();
    chk("t4_spl2_resp", 32'(resp), 32'd3);
    sel = 1'b1; haddr = 14'h030; sb_masters = 2'b10;
    tick();
    sel = 1'b0;
    chk("t4_rty1_ready", 32'(ready), 32'd0);
    chk("t4_rty1_resp", 32'(resp), 32'd2);
    tick();
    chk("t4_rty2_ready", 32'(ready), 32'd1);
    chk("t4_rty2_resp", 32'(resp), 32'd2);
    chk("t4_rty2_ar", 32'(sb_split_ar), 32'd0);
    tick();
    chk("t4_release", 32'(sb_split_ar), 32'd1);
    tick();
    chk("t4_release_end", 32'(sb_split_ar), 32'd0);
    sel = 1'b1; haddr = 14'h020; sb_masters = 2'b01;
    tick();
    sel = 1'b0;
    chk("t4_hit_resp", 32'(resp), 32'd0);
    chk("t4_hit_rdata", rdata, 32'h12345678);
    last_rd = 32'h12345678;
`endif

    // Locked and ownerless accesses take the wait-state path.
    xfer(14'h020, 1'b0, 32'h0, 2'b01, 1'b1, 1'b1);
    xfer(14'h010, 1'b0, 32'h0, 2'b00, 1'b0, 1'b1);

    // A pending split buffer is discarded by any other access.
    xfer(14'h020, 1'b0, 32'h0, 2'b01, 1'b0, 1'b0);
    xfer(14'h020, 1'b0, 32'h0, 2'b10, 1'b1, 1'b1);
    xfer(14'h020, 1'b0, 32'h0, 2'b01, 1'b0, 1'b1);

    // Reset in the second wait cycle of a write drops the write.
    sel = 1'b1; haddr = 14'h010; hwrite = 1'b1; wdata = 32'hCAFEF00D;
    sb_masters = 2'b01; sb_mastlock = 1'b1;
    tick();
    sel = 1'b0;
    chk("t6_wait1", 32'(ready), 32'd0);
    tick();
    chk("t6_wait2", 32'(ready), 32'd0);
    rst = 1'b1;
    #2;
    chk("t6_rst_rdata", rdata, 32'd0);
    chk("t6_rst_resp", 32'(resp), 32'd0);
    chk("t6_rst_ready", 32'(ready), 32'd1);
    chk("t6_rst_ar", 32'(sb_split_ar), 32'd0);
    @(negedge clk) rst = 1'b0;
    last_rd = '0;
    for (int i = 0; i < LAT + 2; i++) begin
      tick();
      chk("t6_no_release", 32'(sb_split_ar), 32'd0);
    end
    xfer(14'h010, 1'b0, 32'h0, 2'b01, 1'b0, 1'b1);
    chk("t6_old_data", rdata, 32'hDEADBEEF);

    // Randomized back-to-back traffic.
    for (int i = 0; i < 40; i++) begin
      wr = ($urandom_range(0, 2) == 0) || (written_q.size() == 0);
      m  = 2'($urandom_range(0, 2));
      lk = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0)
        a = 14'($urandom_range(DEPTH, 16383));
      else if (wr)
        a = 14'($urandom_range(0, DEPTH - 1));
      else
        a = 14'(written_q[$urandom_range(0, written_q.size() - 1)]);
      xfer(a, wr, $urandom, m, lk, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
